pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches ID/EX/MEM stage state and drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM (exe_flush) and MEM/WB registers, plus the PC-source select.
- Handles load-use hazards, taken branches resolved in MEM, precise exceptions raised in MEM, and the multi-cycle multiply/divide unit (MDU) busy window.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The master side is the datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_mdu_use;
    logic [4:0] ex_rd;
    logic [2:0] ex_memread;
    logic       ex_regwrite;
    logic       ex_mdu_start;
    logic       mem_branch;
    logic       mem_zero;
    logic       exc_req;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_exe_flush;
    logic       exe_flush;
    logic       mem_wb_flush;
    logic [1:0] pc_src;
    logic       mdu_busy;
    logic       mdu_cancel;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_mdu_use, ex_rd, ex_memread,
               ex_regwrite, ex_mdu_start, mem_branch, mem_zero, exc_req,
        input  pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_flush,
               mem_wb_flush, pc_src, mdu_busy, mdu_cancel
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_mdu_use, ex_rd, ex_memread,
               ex_regwrite, ex_mdu_start, mem_branch, mem_zero, exc_req,
        output pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_flush,
               mem_wb_flush, pc_src, mdu_busy, mdu_cancel
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM branches, MEM exceptions, MDU busy window.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue; MDU idle
// MDU_WAIT  | MDU op in flight, mdu_cnt counts down to 0 (last busy cycle)
// EXC_DRAIN | single cycle after an exception, squashing IF/ID and ID/EX
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_hazard_ctrl_if.slave    hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    localparam logic [5:0] MDU_LOAD = 6'(MDU_CYCLES - 1);

    state_t     state, state_nxt;
    logic [5:0] mdu_cnt, mdu_cnt_nxt;

    logic load_hz;
    logic br_taken;
    logic mdu_hz;

    assign load_hz  = (hz.ex_memread != 3'd0) && hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    assign br_taken = hz.mem_branch && hz.mem_zero;
    assign mdu_hz   = (state == MDU_WAIT) && hz.id_mdu_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            mdu_cnt <= 6'd0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // A start issued alongside an exception is dropped: that EX instruction is being flushed.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        if (hz.exc_req) begin
            state_nxt   = EXC_DRAIN;
            mdu_cnt_nxt = 6'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hz.ex_mdu_start) begin
                        state_nxt   = MDU_WAIT;
                        mdu_cnt_nxt = MDU_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt == 6'd0) begin
                        state_nxt = RUN;
                    end else begin
                        mdu_cnt_nxt = mdu_cnt - 6'd1;
                    end
                end
                EXC_DRAIN: begin
                    state_nxt   = RUN;
                    mdu_cnt_nxt = 6'd0;
                end
                default: begin
                    state_nxt   = RUN;
                    mdu_cnt_nxt = 6'd0;
                end
            endcase
        end
    end

    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.if_id_stall  = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_exe_flush = 1'b0;
        hz.exe_flush    = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.pc_src       = 2'b00;
        hz.mdu_busy     = 1'b0;
        hz.mdu_cancel   = 1'b0;
        // Reset quiesces everything, including a cancel that would otherwise fire mid-MDU_WAIT.
        if (!reset) begin
            hz.mdu_busy = (state == MDU_WAIT);
            if (hz.exc_req) begin
                hz.pc_src       = 2'b10;
                hz.if_id_flush  = 1'b1;
                hz.id_exe_flush = 1'b1;
                hz.exe_flush    = 1'b1;
                hz.mem_wb_flush = 1'b1;
                hz.mdu_cancel   = (state == MDU_WAIT);
            end else if (state == EXC_DRAIN) begin
                hz.if_id_flush  = 1'b1;
                hz.id_exe_flush = 1'b1;
            end else if (br_taken) begin
                hz.pc_src       = 2'b01;
                hz.if_id_flush  = 1'b1;
                hz.id_exe_flush = 1'b1;
                hz.exe_flush    = 1'b1;
            end else if (load_hz || mdu_hz) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_exe_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (hz.pc_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (hz.exe_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: fixed vectors, directed multi-cycle sequences,
// and randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MDU_N = 4;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if hif();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .hz        (hif.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       reset;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_mdu_use;
        logic [4:0] ex_rd;
        logic [2:0] ex_memread;
        logic       ex_regwrite;
        logic       ex_mdu_start;
        logic       mem_branch;
        logic       mem_zero;
        logic       exc_req;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
        string      name;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;

    // Reference model: remaining busy cycles of the MDU and a pending-drain flag.
    int model_rem = 0;
    bit model_drain = 1'b0;

    // Output vector: {pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_flush, mem_wb_flush, pc_src[1:0], mdu_busy, mdu_cancel}
    function automatic logic [9:0] model_out(input in_t v);
        bit busy, lhz, br, mhz;
        logic [9:0] o;
        o = '0;
        if (v.reset) return o;
        busy = (model_rem > 0);
        lhz  = (v.ex_memread != 0) && v.ex_regwrite && (v.ex_rd != 0) &&
               ((v.ex_rd == v.id_rs) || (v.id_uses_rt && (v.ex_rd == v.id_rt)));
        br   = v.mem_branch && v.mem_zero;
        mhz  = busy && v.id_mdu_use;
        o[1] = busy;
        if (v.exc_req) begin
            o[7:4] = 4'b1111;
            o[3:2] = 2'b10;
            o[0]   = busy;
        end else if (model_drain) begin
            o[7:6] = 2'b11;
        end else if (br) begin
            o[7:5] = 3'b111;
            o[3:2] = 2'b01;
        end else if (lhz || mhz) begin
            o[9] = 1'b1;
            o[8] = 1'b1;
            o[6] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_update(input in_t v);
        if (v.reset) begin
            model_rem   = 0;
            model_drain = 1'b0;
        end else if (v.exc_req) begin
            model_rem   = 0;
            model_drain = 1'b1;
        end else if (model_drain) begin
            model_drain = 1'b0;
        end else if (model_rem > 0) begin
            model_rem = model_rem - 1;
        end else if (v.ex_mdu_start) begin
            model_rem = MDU_N;
        end
    endtask

    task automatic drive(input in_t v);
        reset            = v.reset;
        hif.id_rs        = v.id_rs;
        hif.id_rt        = v.id_rt;
        hif.id_uses_rt   = v.id_uses_rt;
        hif.id_mdu_use   = v.id_mdu_use;
        hif.ex_rd        = v.ex_rd;
        hif.ex_memread   = v.ex_memread;
        hif.ex_regwrite  = v.ex_regwrite;
        hif.ex_mdu_start = v.ex_mdu_start;
        hif.mem_branch   = v.mem_branch;
        hif.mem_zero     = v.mem_zero;
        hif.exc_req      = v.exc_req;
    endtask

    // One clock cycle: drive, check mid-cycle, advance model on the rising edge.
    task automatic step(input in_t v, input bit use_exp, input logic [9:0] exp_c, input string name);
        logic [9:0] expv, act;
        assert (!(model_rem > 0 && !v.reset && v.ex_mdu_start))
            else $error("stimulus issued an MDU start while the MDU was busy");
        drive(v);
        #4;
        expv = use_exp ? exp_c : model_out(v);
        act  = {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_exe_flush, hif.exe_flush,
                hif.mem_wb_flush, hif.pc_src, hif.mdu_busy, hif.mdu_cancel};
        busy_seen += int'(act[1]);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    task automatic add_vec(inout vec_t q[$], input in_t v, input logic [9:0] e, input string n);
        vec_t t;
        t.in   = v;
        t.exp  = e;
        t.name = n;
        q.push_back(t);
    endtask

    function automatic in_t load_use(input logic [4:0] rd);
        in_t v;
        v = '0;
        v.ex_memread  = 3'b001;
        v.ex_regwrite = 1'b1;
        v.ex_rd       = rd;
        v.id_rs       = 5'd5;
        return v;
    endfunction

    localparam logic [9:0] O_IDLE   = 10'b0000000000;
    localparam logic [9:0] O_STALL  = 10'b1101000000;
    localparam logic [9:0] O_BRANCH = 10'b0011100100;

    initial begin
        vec_t tbl[$];
        in_t  v;
        in_t  idle;
        idle = '0;

        // Fixed vectors, all applied with the controller sitting in RUN.
        v = load_use(5'd5); v.reset = 1'b1;   add_vec(tbl, v, O_IDLE,   "reset_outputs");
        add_vec(tbl, idle, O_IDLE, "reset_release_idle");
        v = load_use(5'd5);                   add_vec(tbl, v, O_STALL,  "load_use_rs");
        v = load_use(5'd0); v.id_rs = 5'd0;   add_vec(tbl, v, O_IDLE,   "load_rd_zero");
        v = load_use(5'd7); v.id_rt = 5'd7; v.id_uses_rt = 1'b1;
                                              add_vec(tbl, v, O_STALL,  "load_use_rt");
        v = load_use(5'd7); v.id_rt = 5'd7;   add_vec(tbl, v, O_IDLE,   "load_rt_unused");
        v = load_use(5'd5); v.ex_memread = 3'b000;
                                              add_vec(tbl, v, O_IDLE,   "not_a_load");
        v = load_use(5'd5); v.ex_regwrite = 1'b0;
                                              add_vec(tbl, v, O_IDLE,   "load_no_regwrite");
        v = load_use(5'd5); v.ex_memread = 3'b100;
                                              add_vec(tbl, v, O_STALL,  "load_code4");
        v = load_use(5'd5); v.mem_branch = 1'b1; v.mem_zero = 1'b1;
                                              add_vec(tbl, v, O_BRANCH, "branch_over_load");
        v = idle; v.mem_branch = 1'b1;        add_vec(tbl, v, O_IDLE,   "branch_not_taken");
        v = idle; v.id_mdu_use = 1'b1;        add_vec(tbl, v, O_IDLE,   "mdu_use_idle_unit");

        foreach (tbl[i]) step(tbl[i].in, 1'b1, tbl[i].exp, tbl[i].name);

        // MDU window: busy and stalled exactly MDU_N cycles, released on the next.
        v = idle; v.ex_mdu_start = 1'b1;
        step(v, 1'b1, O_IDLE, "mdu_issue");
        busy_seen = 0;
        v = idle; v.id_mdu_use = 1'b1;
        for (int i = 0; i < MDU_N; i++) step(v, 1'b1, 10'b1101000010, "mdu_wait_stall");
        step(v, 1'b1, O_IDLE, "mdu_released");
        checks++;
        if (busy_seen != MDU_N) begin
            errors++;
            $display("FAIL mdu_busy_cycles: got %0d expected %0d", busy_seen, MDU_N);
        end

        // Branch during MDU_WAIT leaves the MDU running.
        v = idle; v.ex_mdu_start = 1'b1;
        step(v, 1'b1, O_IDLE, "mdu_issue_br");
        v = idle; v.mem_branch = 1'b1; v.mem_zero = 1'b1; v.id_mdu_use = 1'b1;
        step(v, 1'b1, 10'b0011100110, "branch_in_mdu_wait");
        step(idle, 1'b1, 10'b0000000010, "mdu_still_busy");
        for (int i = 0; i < MDU_N - 2; i++) step(idle, 1'b0, O_IDLE, "mdu_finish");
        step(idle, 1'b1, O_IDLE, "mdu_done_after_branch");

        // Exception two counts into the MDU window.
        v = idle; v.ex_mdu_start = 1'b1;
        step(v, 1'b1, O_IDLE, "mdu_issue_exc");
        step(idle, 1'b1, 10'b0000000010, "mdu_busy_first");
        v = idle; v.exc_req = 1'b1;
        step(v, 1'b1, 10'b0011111011, "exc_in_mdu_wait");
        step(idle, 1'b1, 10'b0011000000, "exc_drain");
        v = idle; v.id_mdu_use = 1'b1;
        step(v, 1'b1, O_IDLE, "run_after_drain");

        // Exception together with an MDU start drops the start.
        v = idle; v.exc_req = 1'b1; v.ex_mdu_start = 1'b1;
        step(v, 1'b1, 10'b0011111000, "exc_with_start");
        step(idle, 1'b1, 10'b0011000000, "drain_after_start");
        step(idle, 1'b1, O_IDLE, "no_mdu_after_exc");

        // Reset in the middle of MDU_WAIT.
        v = idle; v.ex_mdu_start = 1'b1;
        step(v, 1'b1, O_IDLE, "mdu_issue_rst");
        step(idle, 1'b1, 10'b0000000010, "mdu_busy_before_rst");
        v = idle; v.reset = 1'b1; v.exc_req = 1'b1; v.id_mdu_use = 1'b1;
        step(v, 1'b1, O_IDLE, "reset_mid_mdu");
        v = idle; v.id_mdu_use = 1'b1;
        step(v, 1'b1, O_IDLE, "run_after_rst");

        // Reset in the middle of EXC_DRAIN.
        v = idle; v.exc_req = 1'b1;
        step(v, 1'b1, 10'b0011111000, "exc_in_run");
        v = idle; v.reset = 1'b1;
        step(v, 1'b1, O_IDLE, "reset_mid_drain");
        step(idle, 1'b1, O_IDLE, "run_after_drain_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v = '0;
            v.reset        = ($urandom_range(0, 63) == 0);
            v.id_rs        = 5'($urandom_range(0, 3));
            v.id_rt        = 5'($urandom_range(0, 3));
            v.id_uses_rt   = 1'($urandom_range(0, 1));
            v.id_mdu_use   = 1'($urandom_range(0, 1));
            v.ex_rd        = 5'($urandom_range(0, 3));
            v.ex_memread   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            v.ex_regwrite  = 1'($urandom_range(0, 1));
            v.ex_mdu_start = (model_rem == 0) && ($urandom_range(0, 7) == 0);
            v.mem_branch   = ($urandom_range(0, 3) == 0);
            v.mem_zero     = 1'($urandom_range(0, 1));
            v.exc_req      = ($urandom_range(0, 15) == 0);
            step(v, 1'b0, O_IDLE, "random");
        end

`ifdef HAZARD_STATS_EN
        v = idle; v.reset = 1'b1;
        step(v, 1'b1, O_IDLE, "stats_reset");
        for (int i = 0; i < 3; i++) step(load_use(5'd5), 1'b1, O_STALL, "stats_load");
        v = idle; v.mem_branch = 1'b1; v.mem_zero = 1'b1;
        for (int i = 0; i < 2; i++) step(v, 1'b1, O_BRANCH, "stats_branch");
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL flush_cnt: got %0d expected 2", flush_cnt);
        end
        v = idle; v.reset = 1'b1;
        step(v, 1'b1, O_IDLE, "stats_reset_again");
        checks++;
        if ((stall_cnt !== 32'd0) || (flush_cnt !== 32'd0)) begin
            errors++;
            $display("FAIL stats_cleared: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
